mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameters ADDR_WIDTH, default 6, memory address width, and DATA_WIDTH, default 16, memory word width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  access request; port 0 is the CPU, port 1 is the debug/loader.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read.
REQ-006 addr0, addr1  input  ADDR_WIDTH each  access address.
REQ-007 wdata0, wdata1  input  DATA_WIDTH each  write data.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse marking the access cycle.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse.
REQ-010 rdata0, rdata1  output  DATA_WIDTH each  read data, held between reads.
REQ-011 mem_we  output  1  memory write enable.
REQ-012 mem_addr  output  ADDR_WIDTH  memory address.
REQ-013 mem_data  output  DATA_WIDTH  memory write data.
REQ-014 mem_in  input  DATA_WIDTH  memory read data; valid one clock after address is sampled.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS and RESP; transitions are IDLE->ACCESS on (req0|req1), ACCESS->RESP unconditionally, and RESP->IDLE unconditionally.
REQ-017 In IDLE with requests pending, the winner SHALL be latched into owner, and its we, addr and wdata SHALL be registered onto mem_we, mem_addr and mem_data.
REQ-018 gnt[owner] SHALL be 1 for exactly the ACCESS cycle.
REQ-019 mem_we SHALL be 1 only during ACCESS and only for a write.
REQ-020 mem_addr and mem_data SHALL hold their last values outside ACCESS.
REQ-021 done[owner] SHALL be 1 for exactly the RESP cycle.
REQ-022 On a read, rdata[owner] SHALL equal mem_in during RESP and SHALL be captured at the end of RESP, then held until the next read completion on that port.
REQ-023 On a write, rdata SHALL be unchanged.
REQ-024 Latency SHALL be req sampled in IDLE at edge N, gnt in cycle N+1, done in cycle N+2; the next arbitration is at edge N+3, giving a maximum of one access per 3 cycles.
REQ-025 Requests SHALL be sampled only in IDLE; req changes during ACCESS and RESP SHALL be ignored.
REQ-026 A requester SHALL hold req, we, addr and wdata until its gnt; a req withdrawn before grant SHALL cause no access.
REQ-027 A requester still asserting req after its done SHALL be treated as a new request at the next IDLE.
REQ-028 Arbitration SHALL be round-robin with a 1-bit last_owner: when both req0 and req1 are high, the port that did not win last SHALL win.
REQ-029 When only one port is requesting, that port SHALL win regardless of last_owner.
REQ-030 last_owner SHALL update at each grant.
REQ-031 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.

Reset
REQ-032 While rst_n=0, regardless of clk: state=IDLE, owner=0, last_owner=1 so port 0 wins the first tie, all gnt, done, mem_we and busy are 0, and mem_addr, mem_data, rdata0 and rdata1 are 0.
REQ-033 A reset asserted during ACCESS SHALL deassert mem_we immediately, and the aborted access SHALL produce no done.

Configuration
REQ-034 The macro MEM_ARBITER_FIXED_PRIO_EN SHALL select the arbitration mode.
REQ-035 When MEM_ARBITER_FIXED_PRIO_EN is defined, port 0 SHALL always win ties, and last_owner SHALL be unused.
REQ-036 When MEM_ARBITER_FIXED_PRIO_EN is undefined, the block SHALL use round-robin per REQ-028 to REQ-030.
REQ-037 All other behaviour SHALL be identical in both modes.

Verification
REQ-038 Reset, then req0=1, we0=1, addr0=5, wdata0=16'h1234 for 1 access -> gnt0 in cycle 2, mem_we=1, mem_addr=5, mem_data=16'h1234, then done0 in cycle 3; read back via port 1 returns rdata1=16'h1234.
REQ-039 req0 and req1 held high continuously, both reading -> grant order 0,1,0,1, one done every 3 cycles, no overlapping gnt or done; with MEM_ARBITER_FIXED_PRIO_EN, only port 0 is served.
REQ-040 req1 asserted alone while last_owner=1 -> port 1 granted immediately, with no wait on port 0.
REQ-041 rst_n pulsed low during ACCESS of a write -> mem_we drops asynchronously, no done, state IDLE, and the next tie is won by port 0.
REQ-042 req0 asserted then deasserted in the same IDLE cycle before an edge -> no gnt0, no memory access, and busy stays 0.
REQ-043 Read on port 0 with mem_in=16'hBEEF in RESP, followed by a write on port 0 -> rdata0 stays 16'hBEEF after the write completes.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-port synchronous memory.
// Port 0 is the CPU and port 1 is the debug/loader. Each access takes three
// cycles (IDLE -> ACCESS -> RESP), so at most one access completes every
// three cycles.
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees its
// gnt pulse. gnt marks the single ACCESS cycle and done marks the single RESP
// cycle. A req still high after done counts as a new request. req is sampled
// only in IDLE.
//
// Configuration macro: MEM_ARBITER_FIXED_PRIO_EN
//   defined   -> port 0 always wins a tie
//   undefined -> round-robin on a 1-bit last_owner; after reset port 0 wins
//                the first tie
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req0/1, we0/1           request, write(1)/read(0)
//   addr0/1, wdata0/1       access address and write data
//   gnt0/1, done0/1         access-cycle and completion pulses
//   rdata0/1                read data, held between reads on that port
//   mem_we/mem_addr/mem_data memory write enable, address and write data
//   mem_in                  memory read data, valid one clock after the address
//   busy                    high whenever the FSM is not in IDLE
//   o_dbg_state             current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
module mem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic                  busy,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  w_req_any;
  logic                  w_pick1;
  logic                  w_resp_rd;

`ifndef MEM_ARBITER_FIXED_PRIO_EN
  logic                  r_last_owner;
`endif

  assign w_req_any = req0 | req1;

`ifdef MEM_ARBITER_FIXED_PRIO_EN
  assign w_pick1 = req1 & ~req0;
`else
  // On a tie, port 1 wins only if port 0 was served last.
  assign w_pick1 = req1 & (~req0 | ~r_last_owner);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_req_any) w_next = ST_ACCESS;
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // A read's data arrives on mem_in during RESP; it is forwarded straight to
  // the owner's rdata and captured on the edge that leaves RESP.
  assign w_resp_rd = (r_state == ST_RESP) && !r_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
      r_last_owner <= 1'b1;
`endif
    end else begin
      if (r_state == ST_IDLE && w_req_any) begin
        r_owner <= w_pick1;
        r_we    <= w_pick1 ? we1 : we0;
        r_addr  <= w_pick1 ? addr1 : addr0;
        r_data  <= w_pick1 ? wdata1 : wdata0;
`ifndef MEM_ARBITER_FIXED_PRIO_EN
        r_last_owner <= w_pick1;
`endif
      end
      if (w_resp_rd) begin
        if (r_owner) r_rdata1 <= mem_in;
        else         r_rdata0 <= mem_in;
      end
    end
  end

  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    mem_we = 1'b0;
    if (r_state == ST_ACCESS) begin
      gnt0   = ~r_owner;
      gnt1   = r_owner;
      // Gated by state so an asynchronous reset drops it at once.
      mem_we = r_we;
    end
    if (r_state == ST_RESP) begin
      done0 = ~r_owner;
      done1 = r_owner;
    end
  end

  assign rdata0      = (w_resp_rd && !r_owner) ? mem_in : r_rdata0;
  assign rdata1      = (w_resp_rd &&  r_owner) ? mem_in : r_rdata1;
  assign mem_addr    = r_addr;
  assign mem_data    = r_data;
  assign busy        = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. A behavioural memory sits on
// the mem_* bus; a separate reference array tracks what the memory should
// hold, expected read data and grant owners go through queues, and every
// comparison is an immediate assertion.
module tb_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, done0, done1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_data;
  logic [DW-1:0] mem_in = '0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    dbg_state;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_in(mem_in), .busy(busy), .o_dbg_state(dbg_state)
  );

  // Behavioural synchronous memory: data valid one clock after the address.
  logic [DW-1:0] tb_mem [0:63];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr] <= mem_data;
    mem_in <= tb_mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] exp_q[$];
  logic          own_q[$];
  logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
  int            total_cnt = 0;
  int            pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic port, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    if (port) begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
  endtask

  // One complete single-requester access from IDLE, checked cycle by cycle.
  task automatic do_access(input string tag, input logic port, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
    logic [DW-1:0] e;
    drive(port, we, a, wd);
    if (we) ref_mem[a] = wd;
    else    exp_q.push_back(ref_mem[a]);
    tick();  // ACCESS
    check({tag, " gnt"}, {gnt1, gnt0}, port ? 2'b10 : 2'b01);
    check({tag, " mem_we"}, mem_we, we);
    check({tag, " mem_addr"}, mem_addr, a);
    if (we) check({tag, " mem_data"}, mem_data, wd);
    req0 = 0; req1 = 0;
    tick();  // RESP
    check({tag, " done"}, {done1, done0}, port ? 2'b10 : 2'b01);
    check({tag, " mem_we resp"}, mem_we, 1'b0);
    if (!we) begin
      e = exp_q.pop_front();
      if (port) exp_rd1 = e; else exp_rd0 = e;
    end
    check({tag, " rdata resp"}, port ? rdata1 : rdata0, port ? exp_rd1 : exp_rd0);
    tick();  // IDLE
    check({tag, " busy idle"}, busy, 1'b0);
    check({tag, " rdata held"}, port ? rdata1 : rdata0, port ? exp_rd1 : exp_rd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    int last_done;
    int cyc;
    logic          cur_owner;
    logic [DW-1:0] e;

    for (int i = 0; i < 64; i++) begin
      tb_mem[i] = '0;
      ref_mem[i] = '0;
    end
    tb_mem[9] = 16'hBEEF;
    ref_mem[9] = 16'hBEEF;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst state", dbg_state, 2'd0);
    check("rst busy", busy, 1'b0);
    check("rst gnt", {gnt1, gnt0}, 2'b00);
    check("rst done", {done1, done0}, 2'b00);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, '0);
    check("rst mem_data", mem_data, '0);
    check("rst rdata", {rdata1, rdata0}, 32'h0);
    rst_n = 1;
    tick();

    // Write on port 0, read back on port 1, then port 1 alone again
    do_access("wr0", 1'b0, 1'b1, 6'd5, 16'h1234);
    do_access("rd1", 1'b1, 1'b0, 6'd5, 16'h0);
    do_access("rd1 again", 1'b1, 1'b0, 6'd5, 16'h0);

    // Read BEEF on port 0, then a write on port 0 must leave rdata0 alone
    do_access("rd0 beef", 1'b0, 1'b0, 6'd9, 16'h0);
    do_access("wr0 keep", 1'b0, 1'b1, 6'd9, 16'h5555);
    check("rdata0 kept", rdata0, 16'hBEEF);
    do_access("rd1 new", 1'b1, 1'b0, 6'd9, 16'h0);

    // Both ports held, both reading
    drive(1'b0, 1'b0, 6'd5, 16'h0);
    drive(1'b1, 1'b0, 6'd9, 16'h0);
`ifdef MEM_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) own_q.push_back(1'b0);
`else
    for (int i = 0; i < 4; i++) own_q.push_back(i[0]);
`endif
    dones = 0;
    last_done = -1;
    cyc = 0;
    cur_owner = 1'b0;
    while (dones < 4 && cyc < 30) begin
      tick();
      cyc++;
      check("tie gnt overlap", gnt0 & gnt1, 1'b0);
      check("tie done overlap", done0 & done1, 1'b0);
      if (gnt0 | gnt1) begin
        cur_owner = own_q.pop_front();
        check("tie owner", gnt1, cur_owner);
        exp_q.push_back(ref_mem[cur_owner ? 6'd9 : 6'd5]);
      end
      if (done0 | done1) begin
        check("tie done port", done1, cur_owner);
        e = exp_q.pop_front();
        check("tie rdata", cur_owner ? rdata1 : rdata0, e);
        if (last_done >= 0) check("tie done spacing", cyc - last_done, 3);
        last_done = cyc;
        dones++;
      end
    end
    check("tie done count", dones, 4);
    req0 = 0; req1 = 0;
    tick();

    // Request pulsed within one IDLE cycle is never seen
    req0 = 1; we0 = 1; addr0 = 6'd3; wdata0 = 16'h7777;
    #2;
    req0 = 0;
    tick();
    check("glitch gnt0", gnt0, 1'b0);
    check("glitch busy", busy, 1'b0);
    check("glitch mem_we", mem_we, 1'b0);
    tick();
    check("glitch busy2", busy, 1'b0);

    // Reset in ACCESS of a port-0 write aborts it
    drive(1'b0, 1'b1, 6'd7, 16'hAAAA);
    tick();
    check("abort mem_we pre", mem_we, 1'b1);
    req0 = 0;
    rst_n = 0;
    #1;
    check("abort mem_we", mem_we, 1'b0);
    check("abort state", dbg_state, 2'd0);
    check("abort busy", busy, 1'b0);
    exp_rd0 = '0;
    exp_rd1 = '0;
    check("abort rdata", {rdata1, rdata0}, 32'h0);
    #2;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no done", {done1, done0}, 2'b00);
    end

    // First tie after reset goes to port 0; the aborted write left no trace
    drive(1'b0, 1'b0, 6'd7, 16'h0);
    drive(1'b1, 1'b0, 6'd9, 16'h0);
    tick();
    check("post rst tie gnt", {gnt1, gnt0}, 2'b01);
    req0 = 0; req1 = 0;
    tick();
    check("post rst done", {done1, done0}, 2'b01);
    check("post rst rdata0", rdata0, ref_mem[7]);
    tick();
    check("post rst idle", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
